regfile_param: RTL and testbench



---
 rtl/regfile_param.sv | 99 +++++++++
 tb/tb_regfile_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with one write port and NREAD
// registered read ports (1-cycle latency, per-port valid).
//
// Parameters:
//   W        data word width
//   AW       address width, depth = 2**AW
//   NREAD    number of read ports (>= 1)
//   ZERO_REG 1 = entry 0 reads as 0 and ignores writes
//
// Ports:
//   clk     clock, all state updates on posedge
//   reset   synchronous active-high reset (clears memory and read ports)
//   wr_en   write strobe
//   waddr   write address
//   wdata   write data
//   rd_en   per-port read request, bit i = port i
//   raddr   read addresses, port i at [i*AW +: AW]
//   rdata   read data, port i at [i*W +: W]
//   rvalid  per-port read-data valid
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-edge write data
// to a read of the same address (default build returns the old value).
module regfile_param #(
    parameter int unsigned W        = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         waddr,
    input  logic [W-1:0]          wdata,
    input  logic [NREAD-1:0]      rd_en,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*W-1:0]    rdata,
    output logic [NREAD-1:0]      rvalid
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0] mem_q [DEPTH];
    logic         wr_fire;

    // Writes to the hardwired-zero entry are dropped.
    assign wr_fire = wr_en && !((ZERO_REG != 0) && (waddr == '0));

    // Storage array; reset clears every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem_q[AW'(j)] <= '0;
            end
        end else if (wr_fire) begin
            mem_q[waddr] <= wdata;
        end
    end

    // One independent registered read port per generate iteration.
    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [AW-1:0] addr;
        logic [W-1:0]  rd_d;
        logic [W-1:0]  rd_q;
        logic          rv_q;

        assign addr = raddr[g*AW +: AW];

        // Next read data: hold unless requested; zero entry masks everything.
        always_comb begin
            rd_d = rd_q;
            if (rd_en[g]) begin
                rd_d = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (addr == waddr)) begin
                    rd_d = wdata;
                end
`endif
                if ((ZERO_REG != 0) && (addr == '0)) begin
                    rd_d = '0;
                end
            end
        end

        // Read data / valid registers; reset kills any in-flight read.
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_q <= '0;
                rv_q <= 1'b0;
            end else begin
                rd_q <= rd_d;
                rv_q <= rd_en[g];
            end
        end

        assign rdata[g*W +: W] = rd_q;
        assign rvalid[g]       = rv_q;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed vector table, randomized
// run against a behavioural array model, and a W=8/AW=3/NREAD=3 sweep.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  rd_en;
    logic [9:0]  raddr;
    logic [63:0] rdata, rdata_z;
    logic [1:0]  rvalid, rvalid_z;

    logic        s_wr_en;
    logic [2:0]  s_waddr;
    logic [7:0]  s_wdata;
    logic [2:0]  s_rd_en;
    logic [8:0]  s_raddr;
    logic [23:0] s_rdata;
    logic [2:0]  s_rvalid;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: index 0 = default DUT, 1 = ZERO_REG=0 DUT, 2 = sweep DUT.
    logic [31:0] mem_m  [3][32];
    logic [31:0] exp_rd [3][3];
    logic [2:0]  exp_rv [3];

    regfile_param #(.W(32), .AW(5), .NREAD(2), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
        .rd_en(rd_en), .raddr(raddr), .rdata(rdata), .rvalid(rvalid));

    regfile_param #(.W(32), .AW(5), .NREAD(2), .ZERO_REG(0)) dut_z0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
        .rd_en(rd_en), .raddr(raddr), .rdata(rdata_z), .rvalid(rvalid_z));

    regfile_param #(.W(8), .AW(3), .NREAD(3), .ZERO_REG(1)) dut_s (
        .clk(clk), .reset(reset), .wr_en(s_wr_en), .waddr(s_waddr), .wdata(s_wdata),
        .rd_en(s_rd_en), .raddr(s_raddr), .rdata(s_rdata), .rvalid(s_rvalid));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge, update the model from the applied inputs, compare all DUTs.
    task automatic tick();
        logic [31:0] v;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  re;
        logic [4:0]  ra [3];
        bit          zr;
        @(posedge clk);
        #1;
        for (logic [1:0] k = 0; k < 2'd3; k++) begin
            if (k < 2'd2) begin
                we = wr_en; wa = waddr; wd = wdata; re = {1'b0, rd_en};
                ra[0] = raddr[4:0]; ra[1] = raddr[9:5]; ra[2] = 5'd0;
            end else begin
                we = s_wr_en; wa = 5'(s_waddr); wd = 32'(s_wdata); re = s_rd_en;
                ra[0] = 5'(s_raddr[2:0]); ra[1] = 5'(s_raddr[5:3]); ra[2] = 5'(s_raddr[8:6]);
            end
            zr = (k != 2'd1);
            if (reset) begin
                for (int a = 0; a < 32; a++) mem_m[k][5'(a)] = '0;
                for (logic [1:0] p = 0; p < 2'd3; p++) exp_rd[k][p] = '0;
                exp_rv[k] = '0;
            end else begin
                for (logic [1:0] p = 0; p < 2'd3; p++) begin
                    if (re[p]) begin
                        v = mem_m[k][ra[p]];
                        if (BYP && we && ra[p] == wa) v = wd;
                        if (zr && ra[p] == 5'd0) v = '0;
                        exp_rd[k][p] = v;
                        exp_rv[k][p] = 1'b1;
                    end else begin
                        exp_rv[k][p] = 1'b0;
                    end
                end
                if (we && !(zr && wa == 5'd0)) mem_m[k][wa] = wd;
            end
        end
        chk("model_rdata",    rdata,            {exp_rd[0][1], exp_rd[0][0]});
        chk("model_rvalid",   64'(rvalid),      64'(exp_rv[0][1:0]));
        chk("model_z0_rdata", rdata_z,          {exp_rd[1][1], exp_rd[1][0]});
        chk("model_z0_rvalid",64'(rvalid_z),    64'(exp_rv[1][1:0]));
        chk("model_s_rdata",  64'(s_rdata),     64'({exp_rd[2][2][7:0], exp_rd[2][1][7:0], exp_rd[2][0][7:0]}));
        chk("model_s_rvalid", 64'(s_rvalid),    64'(exp_rv[2]));
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  ev;
    } vec_t;

    localparam int NV = 15;
    localparam logic [31:0] RDW_EXP = BYP ? 32'h5555FFFF : 32'hAAAA0000;

    vec_t vecs [NV];

    initial begin
        // Expected outputs (default ZERO_REG=1 DUT) after each row's edge.
        vecs[0]  = '{1'b1, 1'b0, 5'd0, 32'h0,        2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00};
        vecs[1]  = '{1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00};
        vecs[2]  = '{1'b1, 1'b0, 5'd0, 32'h0,        2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00};
        vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,        2'b01, 5'd7, 5'd0, 32'h0,        32'h0,        2'b01};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,        2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00};
        vecs[5]  = '{1'b0, 1'b1, 5'd3, 32'h12345678, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00};
        vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,        2'b11, 5'd3, 5'd3, 32'h12345678, 32'h12345678, 2'b11};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,        2'b00, 5'd0, 5'd0, 32'h12345678, 32'h12345678, 2'b00};
        vecs[8]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 2'b00, 5'd0, 5'd0, 32'h12345678, 32'h12345678, 2'b00};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'h0,        2'b01, 5'd0, 5'd0, 32'h0,        32'h12345678, 2'b01};
        vecs[10] = '{1'b0, 1'b1, 5'd5, 32'hAAAA0000, 2'b00, 5'd0, 5'd0, 32'h0,        32'h12345678, 2'b00};
        vecs[11] = '{1'b0, 1'b1, 5'd5, 32'h5555FFFF, 2'b10, 5'd0, 5'd5, 32'h0,        RDW_EXP,      2'b10};
        vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0,        2'b10, 5'd0, 5'd5, 32'h0,        32'h5555FFFF, 2'b10};
        vecs[13] = '{1'b1, 1'b1, 5'd9, 32'h00000042, 2'b11, 5'd9, 5'd9, 32'h0,        32'h0,        2'b00};
        vecs[14] = '{1'b0, 1'b0, 5'd0, 32'h0,        2'b01, 5'd9, 5'd0, 32'h0,        32'h0,        2'b01};

        reset = 1'b1; wr_en = 1'b0; waddr = '0; wdata = '0; rd_en = '0; raddr = '0;
        s_wr_en = 1'b0; s_waddr = '0; s_wdata = '0; s_rd_en = '0; s_raddr = '0;

        // Directed table.
        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst; wr_en = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
            rd_en = vecs[i].re; raddr = {vecs[i].ra1, vecs[i].ra0};
            tick();
            chk($sformatf("vec%0d_rdata0", i), 64'(rdata[31:0]),  64'(vecs[i].e0));
            chk($sformatf("vec%0d_rdata1", i), 64'(rdata[63:32]), 64'(vecs[i].e1));
            chk($sformatf("vec%0d_rvalid", i), 64'(rvalid),       64'(vecs[i].ev));
        end

        // ZERO_REG=0 instance: write 0xFFFFFFFF to entry 0 then read it back.
        reset = 1'b0; wr_en = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; rd_en = 2'b00;
        tick();
        wr_en = 1'b0; rd_en = 2'b01; raddr = '0;
        tick();
        chk("z0_entry0_rdata", 64'(rdata_z[31:0]), 64'h00000000FFFFFFFF);
        chk("zr_entry0_rdata", 64'(rdata[31:0]),   64'h0);

        // Randomized traffic on all three instances.
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 31) == 0);
            wr_en   = 1'($urandom);
            waddr   = 5'($urandom_range(0, 7));
            wdata   = $urandom;
            rd_en   = 2'($urandom);
            raddr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            s_wr_en = 1'($urandom);
            s_waddr = 3'($urandom);
            s_wdata = 8'($urandom);
            s_rd_en = 3'($urandom);
            s_raddr = 9'($urandom);
            tick();
        end

        // Sweep instance: fill 1..7 with 0x10+addr, then concurrent reads 7/1/4.
        reset = 1'b1; wr_en = 1'b0; rd_en = '0; s_wr_en = 1'b0; s_rd_en = '0;
        tick();
        reset = 1'b0;
        for (int a = 1; a < 8; a++) begin
            s_wr_en = 1'b1; s_waddr = 3'(a); s_wdata = 8'(8'h10 + a);
            tick();
        end
        s_wr_en = 1'b0; s_rd_en = 3'b111; s_raddr = {3'd4, 3'd1, 3'd7};
        tick();
        chk("sweep_rdata",  64'(s_rdata),  64'h141117);
        chk("sweep_rvalid", 64'(s_rvalid), 64'h7);
        s_rd_en = 3'b000;
        tick();
        chk("sweep_idle_rvalid", 64'(s_rvalid), 64'h0);
        chk("sweep_idle_hold",   64'(s_rdata),  64'h141117);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
